streamblocks_ctrl_axil_slave: RTL and testbench

Parametrised AXI4-Lite control slave for StreamBlocks HLS kernels, with NUM_IN input and NUM_OUT output port register banks (size, pointer, buffer) generated from a computed address map. It adds independent AW/W acceptance, SLVERR on bad accesses, an ap_continue (ap_ctrl_chain) handshake and read-only per-port progress counters. It sits between the host/XRT AXI-Lite bus and the kernel top-level FSM.

---
 rtl/streamblocks_ctrl_pkg.sv | 73 +++++++
 rtl/streamblocks_ctrl_port_bank.sv | 82 ++++++++
 rtl/streamblocks_ctrl_axil_slave.sv | 267 ++++++++++++++++++++++++++
 tb/tb_streamblocks_ctrl_axil_slave.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/streamblocks_ctrl_pkg.sv
// Shared address map, response codes and decode helpers for the StreamBlocks
// AXI4-Lite control slave.
package streamblocks_ctrl_pkg;

    localparam logic [31:0] ADDR_AP_CTRL = 32'h00;
    localparam logic [31:0] ADDR_GIE     = 32'h04;
    localparam logic [31:0] ADDR_IER     = 32'h08;
    localparam logic [31:0] ADDR_ISR     = 32'h0C;
    localparam logic [31:0] ADDR_KCMD_LO = 32'h10;
    localparam logic [31:0] ADDR_KCMD_HI = 32'h14;
    localparam logic [31:0] ADDR_INFO    = 32'h18;

    localparam logic [31:0] BANK_BASE   = 32'h20;
    localparam logic [31:0] BANK_STRIDE = 32'h20;

    localparam logic [4:0] OFF_REQ     = 5'h00;
    localparam logic [4:0] OFF_SIZE_LO = 5'h04;
    localparam logic [4:0] OFF_SIZE_HI = 5'h08;
    localparam logic [4:0] OFF_BUF_LO  = 5'h0C;
    localparam logic [4:0] OFF_BUF_HI  = 5'h10;
    localparam logic [4:0] OFF_CNT     = 5'h14;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [2:0] {
        FLD_REQ,
        FLD_SIZE_LO,
        FLD_SIZE_HI,
        FLD_BUF_LO,
        FLD_BUF_HI,
        FLD_CNT
    } field_e;

    typedef struct packed {
        logic       valid;
        logic [3:0] bank;
        field_e     field;
    } bank_sel_t;

    // Maps a byte address onto (bank, field); hi words only exist for 64-bit pointers.
    function automatic bank_sel_t decode_bank(input logic [31:0] addr,
                                              input logic [4:0]  nbanks,
                                              input logic        ptr64);
        logic [31:0] rel;
        logic [31:0] idx;
        decode_bank = '{valid: 1'b0, bank: 4'd0, field: FLD_REQ};
        rel = addr - BANK_BASE;
        idx = rel / BANK_STRIDE;
        if ((addr >= BANK_BASE) && (idx < {27'd0, nbanks})) begin
            decode_bank.bank  = idx[3:0];
            decode_bank.valid = 1'b1;
            case (rel[4:0] & 5'h1C)
                OFF_REQ:     decode_bank.field = FLD_REQ;
                OFF_SIZE_LO: decode_bank.field = FLD_SIZE_LO;
                OFF_SIZE_HI: begin decode_bank.field = FLD_SIZE_HI; decode_bank.valid = ptr64; end
                OFF_BUF_LO:  decode_bank.field = FLD_BUF_LO;
                OFF_BUF_HI:  begin decode_bank.field = FLD_BUF_HI; decode_bank.valid = ptr64; end
                OFF_CNT:     decode_bank.field = FLD_CNT;
                default:     decode_bank.valid = 1'b0;
            endcase
        end
    endfunction

    function automatic logic [31:0] apply_strb(input logic [31:0] old_v,
                                               input logic [31:0] new_v,
                                               input logic [3:0]  strb);
        for (int i = 0; i < 4; i++) begin
            apply_strb[8*i +: 8] = strb[i] ? new_v[8*i +: 8] : old_v[8*i +: 8];
        end
    endfunction

endpackage

// File: rtl/streamblocks_ctrl_port_bank.sv
// One kernel port's register bank: requested/available size, size pointer and
// buffer pointer, with byte-masked writes and a word read mux.
module streamblocks_ctrl_port_bank
    import streamblocks_ctrl_pkg::*;
#(
    parameter int PTR_WIDTH = 64
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic                 i_en,
    input  logic                 i_wr_en,
    input  field_e               i_wr_field,
    input  logic [31:0]          i_wdata,
    input  logic [3:0]           i_wstrb,
    input  field_e               i_rd_field,
    input  logic [31:0]          i_cnt,
    output logic [31:0]          o_req,
    output logic [PTR_WIDTH-1:0] o_size,
    output logic [PTR_WIDTH-1:0] o_buf,
    output logic [31:0]          o_rdata
);

    logic [31:0] r_req;
    logic [31:0] r_size_lo;
    logic [31:0] r_buf_lo;
    logic [31:0] w_size_hi;
    logic [31:0] w_buf_hi;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_req     <= '0;
            r_size_lo <= '0;
            r_buf_lo  <= '0;
        end else if (i_en && i_wr_en) begin
            case (i_wr_field)
                FLD_REQ:     r_req     <= apply_strb(r_req, i_wdata, i_wstrb);
                FLD_SIZE_LO: r_size_lo <= apply_strb(r_size_lo, i_wdata, i_wstrb);
                FLD_BUF_LO:  r_buf_lo  <= apply_strb(r_buf_lo, i_wdata, i_wstrb);
                default: ;
            endcase
        end
    end

    if (PTR_WIDTH == 64) begin : g_hi
        logic [31:0] r_size_hi;
        logic [31:0] r_buf_hi;
        always_ff @(posedge i_clk or negedge i_rst_n) begin
            if (!i_rst_n) begin
                r_size_hi <= '0;
                r_buf_hi  <= '0;
            end else if (i_en && i_wr_en) begin
                if (i_wr_field == FLD_SIZE_HI) r_size_hi <= apply_strb(r_size_hi, i_wdata, i_wstrb);
                if (i_wr_field == FLD_BUF_HI)  r_buf_hi  <= apply_strb(r_buf_hi, i_wdata, i_wstrb);
            end
        end
        assign w_size_hi = r_size_hi;
        assign w_buf_hi  = r_buf_hi;
        assign o_size    = {r_size_hi, r_size_lo};
        assign o_buf     = {r_buf_hi, r_buf_lo};
    end else begin : g_no_hi
        assign w_size_hi = '0;
        assign w_buf_hi  = '0;
        assign o_size    = r_size_lo;
        assign o_buf     = r_buf_lo;
    end

    assign o_req = r_req;

    always_comb begin
        o_rdata = '0;
        case (i_rd_field)
            FLD_REQ:     o_rdata = r_req;
            FLD_SIZE_LO: o_rdata = r_size_lo;
            FLD_SIZE_HI: o_rdata = w_size_hi;
            FLD_BUF_LO:  o_rdata = r_buf_lo;
            FLD_BUF_HI:  o_rdata = w_buf_hi;
            FLD_CNT:     o_rdata = i_cnt;
            default:     o_rdata = '0;
        endcase
    end

endmodule

// File: rtl/streamblocks_ctrl_axil_slave.sv
// AXI4-Lite control slave for StreamBlocks HLS kernels: ap_ctrl_chain block
// control, interrupts, kernel command and per-port register banks.
module streamblocks_ctrl_axil_slave
    import streamblocks_ctrl_pkg::*;
#(
    parameter int NUM_IN     = 1,
    parameter int NUM_OUT    = 1,
    parameter int ADDR_WIDTH = 7,
    parameter int DATA_WIDTH = 32,
    parameter int PTR_WIDTH  = 64
) (
    input  logic                           ACLK,
    input  logic                           ARESETN,
    input  logic                           ACLK_EN,
    input  logic [ADDR_WIDTH-1:0]          AWADDR,
    input  logic                           AWVALID,
    output logic                           AWREADY,
    input  logic [DATA_WIDTH-1:0]          WDATA,
    input  logic [DATA_WIDTH/8-1:0]        WSTRB,
    input  logic                           WVALID,
    output logic                           WREADY,
    output logic [1:0]                     BRESP,
    output logic                           BVALID,
    input  logic                           BREADY,
    input  logic [ADDR_WIDTH-1:0]          ARADDR,
    input  logic                           ARVALID,
    output logic                           ARREADY,
    output logic [DATA_WIDTH-1:0]          RDATA,
    output logic [1:0]                     RRESP,
    output logic                           RVALID,
    input  logic                           RREADY,
    output logic [NUM_IN*32-1:0]           in_requested_size,
    output logic [NUM_IN*PTR_WIDTH-1:0]    in_size,
    output logic [NUM_IN*PTR_WIDTH-1:0]    in_buffer,
    output logic [NUM_OUT*32-1:0]          out_available_size,
    output logic [NUM_OUT*PTR_WIDTH-1:0]   out_size,
    output logic [NUM_OUT*PTR_WIDTH-1:0]   out_buffer,
    input  logic [NUM_IN*32-1:0]           in_consumed,
    input  logic [NUM_OUT*32-1:0]          out_produced,
    output logic [63:0]                    kernel_command,
    output logic                           ap_start,
    output logic                           ap_continue,
    output logic                           event_start,
    output logic                           interrupt,
    input  logic                           ap_done,
    input  logic                           ap_ready,
    input  logic                           ap_idle
);

    localparam int NB = NUM_IN + NUM_OUT;

    logic                    r_init;
    logic                    r_aw_held, r_w_held, r_bvalid, r_rvalid;
    logic [ADDR_WIDTH-1:0]   r_awaddr;
    logic [DATA_WIDTH-1:0]   r_wdata;
    logic [DATA_WIDTH/8-1:0] r_wstrb;
    logic [1:0]              r_bresp, r_rresp;
    logic [DATA_WIDTH-1:0]   r_rdata;
    logic                    r_ap_start, r_done, r_idle, r_ready, r_auto_restart;
    logic                    r_ap_continue, r_event_start, r_gie;
    logic [1:0]              r_ier, r_isr;
    logic [63:0]             r_kcmd;

    logic        w_aw_hs, w_w_hs, w_b_hs, w_ar_hs, w_r_hs, w_wr_exec;
    logic [31:0] w_waddr, w_raddr, w_info, w_rdata, w_bank_rdata;
    logic [2:0]  w_widx, w_ridx;
    logic        w_wctl, w_rctl, w_wok, w_rok, w_wr_ctl, w_wr_ap, w_wr_isr, w_rd_ap;
    logic [1:0]  w_isr_src;
    bank_sel_t   w_wsel, w_rsel;
    logic [31:0] w_bank_rd [NB];

    assign AWREADY = r_init & ~r_aw_held;
    assign WREADY  = r_init & ~r_w_held;
    assign ARREADY = r_init & ~r_rvalid;
    assign BVALID  = r_bvalid;
    assign BRESP   = r_bresp;
    assign RVALID  = r_rvalid;
    assign RRESP   = r_rresp;
    assign RDATA   = r_rdata;

    assign w_aw_hs   = AWVALID & AWREADY;
    assign w_w_hs    = WVALID & WREADY;
    assign w_b_hs    = r_bvalid & BREADY;
    assign w_ar_hs   = ARVALID & ARREADY;
    assign w_r_hs    = r_rvalid & RREADY;
    assign w_wr_exec = r_aw_held & r_w_held & ~r_bvalid;

    assign w_waddr  = 32'(r_awaddr);
    assign w_raddr  = 32'(ARADDR);
    assign w_widx   = w_waddr[4:2];
    assign w_ridx   = w_raddr[4:2];
    assign w_wctl   = w_waddr < BANK_BASE;
    assign w_rctl   = w_raddr < BANK_BASE;
    assign w_wsel   = decode_bank(w_waddr, 5'(NB), PTR_WIDTH == 64);
    assign w_rsel   = decode_bank(w_raddr, 5'(NB), PTR_WIDTH == 64);
    // Control words 0x00..0x14 are writable; INFO, counters and holes are not.
    assign w_wok    = w_wctl ? (w_widx <= 3'd5) : (w_wsel.valid && (w_wsel.field != FLD_CNT));
    assign w_wr_ctl = w_wr_exec & w_wctl;
    assign w_wr_ap  = w_wr_ctl & (w_widx == ADDR_AP_CTRL[4:2]) & r_wstrb[0];
    assign w_wr_isr = w_wr_ctl & (w_widx == ADDR_ISR[4:2]) & r_wstrb[0];
    assign w_rd_ap  = w_ar_hs & w_rctl & (w_ridx == ADDR_AP_CTRL[4:2]);
    assign w_isr_src = {ap_ready, ap_done};
    assign w_info   = {8'd0, 8'(PTR_WIDTH), 8'(NUM_OUT), 8'(NUM_IN)};

    for (genvar b = 0; b < NB; b++) begin : g_bank
        logic [31:0]          w_req, w_cnt;
        logic [PTR_WIDTH-1:0] w_size, w_buf;

        streamblocks_ctrl_port_bank #(.PTR_WIDTH(PTR_WIDTH)) u_bank (
            .i_clk      (ACLK),
            .i_rst_n    (ARESETN),
            .i_en       (ACLK_EN),
            .i_wr_en    (w_wr_exec && w_wok && !w_wctl && (w_wsel.bank == 4'(b))),
            .i_wr_field (w_wsel.field),
            .i_wdata    (r_wdata),
            .i_wstrb    (r_wstrb),
            .i_rd_field (w_rsel.field),
            .i_cnt      (w_cnt),
            .o_req      (w_req),
            .o_size     (w_size),
            .o_buf      (w_buf),
            .o_rdata    (w_bank_rd[b])
        );

        if (b < NUM_IN) begin : g_in
            assign in_requested_size[32*b +: 32]       = w_req;
            assign in_size[PTR_WIDTH*b +: PTR_WIDTH]   = w_size;
            assign in_buffer[PTR_WIDTH*b +: PTR_WIDTH] = w_buf;
            assign w_cnt = in_consumed[32*b +: 32];
        end else begin : g_out
            assign out_available_size[32*(b-NUM_IN) +: 32]       = w_req;
            assign out_size[PTR_WIDTH*(b-NUM_IN) +: PTR_WIDTH]   = w_size;
            assign out_buffer[PTR_WIDTH*(b-NUM_IN) +: PTR_WIDTH] = w_buf;
            assign w_cnt = out_produced[32*(b-NUM_IN) +: 32];
        end
    end

    always_comb begin
        w_bank_rdata = '0;
        for (int b = 0; b < NB; b++) begin
            if (w_rsel.bank == 4'(b)) w_bank_rdata = w_bank_rd[b];
        end
    end

    always_comb begin
        w_rdata = '0;
        w_rok   = 1'b0;
        if (w_rctl) begin
            w_rok = 1'b1;
            case (w_ridx)
                3'd0:    w_rdata = {24'd0, r_auto_restart, 2'b00, r_ap_continue,
                                    r_ready, r_idle, r_done, r_ap_start};
                3'd1:    w_rdata = {31'd0, r_gie};
                3'd2:    w_rdata = {30'd0, r_ier};
                3'd3:    w_rdata = {30'd0, r_isr};
                3'd4:    w_rdata = r_kcmd[31:0];
                3'd5:    w_rdata = r_kcmd[63:32];
                3'd6:    w_rdata = w_info;
                default: w_rok   = 1'b0;
            endcase
        end else if (w_rsel.valid) begin
            w_rok   = 1'b1;
            w_rdata = w_bank_rdata;
        end
    end

    // Write channel: AW and W are held independently until the B handshake.
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            r_init    <= 1'b0;
            r_aw_held <= 1'b0;
            r_w_held  <= 1'b0;
            r_awaddr  <= '0;
            r_wdata   <= '0;
            r_wstrb   <= '0;
            r_bvalid  <= 1'b0;
            r_bresp   <= RESP_OKAY;
        end else if (ACLK_EN) begin
            r_init <= 1'b1;
            if (w_aw_hs) begin
                r_aw_held <= 1'b1;
                r_awaddr  <= AWADDR;
            end
            if (w_w_hs) begin
                r_w_held <= 1'b1;
                r_wdata  <= WDATA;
                r_wstrb  <= WSTRB;
            end
            if (w_wr_exec) begin
                r_bvalid <= 1'b1;
                r_bresp  <= w_wok ? RESP_OKAY : RESP_SLVERR;
            end
            if (w_b_hs) begin
                r_bvalid  <= 1'b0;
                r_aw_held <= 1'b0;
                r_w_held  <= 1'b0;
            end
        end
    end

    // Read channel: data and counters are captured at the AR handshake.
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            r_rvalid <= 1'b0;
            r_rdata  <= '0;
            r_rresp  <= RESP_OKAY;
        end else if (ACLK_EN) begin
            if (w_ar_hs) begin
                r_rvalid <= 1'b1;
                r_rdata  <= w_rdata;
                r_rresp  <= w_rok ? RESP_OKAY : RESP_SLVERR;
            end else if (w_r_hs) begin
                r_rvalid <= 1'b0;
            end
        end
    end

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            r_ap_start     <= 1'b0;
            r_done         <= 1'b0;
            r_idle         <= 1'b0;
            r_ready        <= 1'b0;
            r_auto_restart <= 1'b0;
            r_ap_continue  <= 1'b0;
            r_event_start  <= 1'b0;
            r_gie          <= 1'b0;
            r_ier          <= '0;
            r_isr          <= '0;
            r_kcmd         <= '0;
        end else if (ACLK_EN) begin
            r_idle        <= ap_idle;
            r_ready       <= ap_ready;
            r_event_start <= 1'b0;
            r_ap_continue <= ap_done & r_auto_restart;
            if (w_wr_ap) begin
                r_auto_restart <= r_wdata[7];
                if (r_wdata[4]) r_ap_continue <= 1'b1;
            end
            if (w_wr_ap && r_wdata[0]) begin
                r_ap_start    <= 1'b1;
                r_event_start <= 1'b1;
            end else if (ap_ready) begin
                r_ap_start <= r_auto_restart;
            end
            if (ap_done)      r_done <= 1'b1;
            else if (w_rd_ap) r_done <= 1'b0;
            if (w_wr_ctl && (w_widx == ADDR_GIE[4:2]) && r_wstrb[0]) r_gie <= r_wdata[0];
            if (w_wr_ctl && (w_widx == ADDR_IER[4:2]) && r_wstrb[0]) r_ier <= r_wdata[1:0];
            for (int i = 0; i < 2; i++) begin
                if (r_ier[i] && w_isr_src[i])     r_isr[i] <= 1'b1;
                else if (w_wr_isr && r_wdata[i]) r_isr[i] <= ~r_isr[i];
            end
            if (w_wr_ctl && (w_widx == ADDR_KCMD_LO[4:2]))
                r_kcmd[31:0]  <= apply_strb(r_kcmd[31:0], r_wdata, r_wstrb);
            if (w_wr_ctl && (w_widx == ADDR_KCMD_HI[4:2]))
                r_kcmd[63:32] <= apply_strb(r_kcmd[63:32], r_wdata, r_wstrb);
        end
    end

    assign ap_start       = r_ap_start;
    assign ap_continue    = r_ap_continue;
    assign event_start    = r_event_start;
    assign kernel_command = r_kcmd;
    assign interrupt      = r_gie & (|r_isr);

endmodule

// File: tb/tb_streamblocks_ctrl_axil_slave.sv
// Directed bench for streamblocks_ctrl_axil_slave with two input banks and one
// output bank using 64-bit pointers.
module tb_streamblocks_ctrl_axil_slave;

    logic         ACLK = 1'b0;
    logic         ARESETN, ACLK_EN;
    logic [6:0]   AWADDR, ARADDR;
    logic         AWVALID, WVALID, BREADY, ARVALID, RREADY;
    logic         AWREADY, WREADY, BVALID, ARREADY, RVALID;
    logic [31:0]  WDATA, RDATA;
    logic [3:0]   WSTRB;
    logic [1:0]   BRESP, RRESP;
    logic [63:0]  in_requested_size;
    logic [127:0] in_size, in_buffer;
    logic [31:0]  out_available_size;
    logic [63:0]  out_size, out_buffer;
    logic [63:0]  in_consumed;
    logic [31:0]  out_produced;
    logic [63:0]  kernel_command;
    logic         ap_start, ap_continue, event_start, interrupt;
    logic         ap_done, ap_ready, ap_idle;

    int n_pass = 0;
    int n_total = 0;
    int ev_cnt = 0;
    int cont_cnt = 0;

    streamblocks_ctrl_axil_slave #(
        .NUM_IN(2), .NUM_OUT(1), .ADDR_WIDTH(7), .DATA_WIDTH(32), .PTR_WIDTH(64)
    ) dut (
        .ACLK(ACLK), .ARESETN(ARESETN), .ACLK_EN(ACLK_EN),
        .AWADDR(AWADDR), .AWVALID(AWVALID), .AWREADY(AWREADY),
        .WDATA(WDATA), .WSTRB(WSTRB), .WVALID(WVALID), .WREADY(WREADY),
        .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
        .ARADDR(ARADDR), .ARVALID(ARVALID), .ARREADY(ARREADY),
        .RDATA(RDATA), .RRESP(RRESP), .RVALID(RVALID), .RREADY(RREADY),
        .in_requested_size(in_requested_size), .in_size(in_size), .in_buffer(in_buffer),
        .out_available_size(out_available_size), .out_size(out_size), .out_buffer(out_buffer),
        .in_consumed(in_consumed), .out_produced(out_produced),
        .kernel_command(kernel_command), .ap_start(ap_start), .ap_continue(ap_continue),
        .event_start(event_start), .interrupt(interrupt),
        .ap_done(ap_done), .ap_ready(ap_ready), .ap_idle(ap_idle)
    );

    always #5 ACLK = ~ACLK;

    always @(posedge ACLK) begin
        if (event_start) ev_cnt <= ev_cnt + 1;
        if (ap_continue) cont_cnt <= cont_cnt + 1;
    end

    task automatic tick();
        @(posedge ACLK);
        #1;
    endtask

    task automatic send_aw(input logic [6:0] a);
        int n = 0;
        AWADDR = a; AWVALID = 1'b1;
        while (!AWREADY && n < 20) begin tick(); n++; end
        n_total++; if (n >= 20) $display("FAIL aw_timeout got=%0d cycles exp<20", n); else n_pass++;
        tick();
        AWVALID = 1'b0;
    endtask

    task automatic send_w(input logic [31:0] d, input logic [3:0] s);
        int n = 0;
        WDATA = d; WSTRB = s; WVALID = 1'b1;
        while (!WREADY && n < 20) begin tick(); n++; end
        n_total++; if (n >= 20) $display("FAIL w_timeout got=%0d cycles exp<20", n); else n_pass++;
        tick();
        WVALID = 1'b0;
    endtask

    task automatic wait_b(output logic [1:0] resp);
        int n = 0;
        while (!BVALID && n < 20) begin tick(); n++; end
        n_total++; if (n >= 20) $display("FAIL b_timeout got=%0d cycles exp<20", n); else n_pass++;
        resp = BRESP;
        BREADY = 1'b1;
        tick();
        BREADY = 1'b0;
    endtask

    // w_first: W goes first and AW follows after gap idle cycles.
    task automatic axi_write(input logic [6:0] a, input logic [31:0] d, input logic [3:0] s,
                             input bit w_first, input int gap, output logic [1:0] resp);
        if (w_first) begin
            send_w(d, s);
            repeat (gap) tick();
            send_aw(a);
        end else begin
            send_aw(a);
            repeat (gap) tick();
            send_w(d, s);
        end
        wait_b(resp);
    endtask

    task automatic axi_read(input logic [6:0] a, output logic [31:0] d, output logic [1:0] resp);
        int n = 0;
        ARADDR = a; ARVALID = 1'b1;
        while (!ARREADY && n < 20) begin tick(); n++; end
        tick();
        ARVALID = 1'b0;
        while (!RVALID && n < 40) begin tick(); n++; end
        n_total++; if (n >= 40) $display("FAIL r_timeout got=%0d cycles exp<40", n); else n_pass++;
        d = RDATA; resp = RRESP;
        RREADY = 1'b1;
        tick();
        RREADY = 1'b0;
    endtask

    task automatic test_reset();
        repeat (3) tick();
        n_total++; if (AWREADY !== 1'b0) $display("FAIL rst_awready got=%b exp=0", AWREADY); else n_pass++;
        n_total++; if (BVALID !== 1'b0 || RVALID !== 1'b0) $display("FAIL rst_valids got=%b%b exp=00", BVALID, RVALID); else n_pass++;
        n_total++; if (in_size !== '0 || kernel_command !== '0) $display("FAIL rst_regs got=%h exp=0", in_size); else n_pass++;
        n_total++; if ({ap_start, ap_continue, event_start, interrupt} !== 4'b0) $display("FAIL rst_ctrl got=%b exp=0000", {ap_start, ap_continue, event_start, interrupt}); else n_pass++;
        ARESETN = 1'b1;
        tick();
        n_total++; if ({AWREADY, WREADY, ARREADY} !== 3'b111) $display("FAIL rst_readies got=%b exp=111", {AWREADY, WREADY, ARREADY}); else n_pass++;
    endtask

    task automatic test_write_order();
        logic [1:0] resp; logic [31:0] d;
        axi_write(7'h44, 32'hDEADBEEF, 4'hF, 1'b1, 3, resp);
        n_total++; if (resp !== 2'b00) $display("FAIL wfirst_bresp got=%b exp=00", resp); else n_pass++;
        n_total++; if (in_size[127:96] !== 32'h0) $display("FAIL wfirst_hi got=%h exp=0", in_size[127:96]); else n_pass++;
        n_total++; if (in_size[95:64] !== 32'hDEADBEEF) $display("FAIL wfirst_lo got=%h exp=deadbeef", in_size[95:64]); else n_pass++;
        axi_read(7'h44, d, resp);
        n_total++; if (d !== 32'hDEADBEEF || resp !== 2'b00) $display("FAIL wfirst_readback got=%h/%b exp=deadbeef/00", d, resp); else n_pass++;
        axi_write(7'h6C, 32'h0BADF00D, 4'hF, 1'b0, 2, resp);
        n_total++; if (resp !== 2'b00 || out_buffer[31:0] !== 32'h0BADF00D) $display("FAIL awfirst_outbuf got=%h exp=0badf00d", out_buffer[31:0]); else n_pass++;
        n_total++; if (in_size[63:0] !== 64'h0) $display("FAIL awfirst_bank0 got=%h exp=0", in_size[63:0]); else n_pass++;
    endtask

    task automatic test_strobe();
        logic [1:0] resp; logic [31:0] d;
        axi_write(7'h20, 32'h12345678, 4'b0010, 1'b0, 0, resp);
        n_total++; if (in_requested_size[31:0] !== 32'h00005600) $display("FAIL strobe got=%h exp=00005600", in_requested_size[31:0]); else n_pass++;
        axi_read(7'h20, d, resp);
        n_total++; if (d !== 32'h00005600) $display("FAIL strobe_readback got=%h exp=00005600", d); else n_pass++;
    endtask

    task automatic test_errors();
        logic [1:0] resp; logic [31:0] d;
        axi_read(7'h7C, d, resp);
        n_total++; if (resp !== 2'b10 || d !== 32'h0) $display("FAIL unmapped_read got=%h/%b exp=0/10", d, resp); else n_pass++;
        axi_write(7'h18, 32'hFFFFFFFF, 4'hF, 1'b0, 0, resp);
        n_total++; if (resp !== 2'b10) $display("FAIL info_write got=%b exp=10", resp); else n_pass++;
        axi_read(7'h18, d, resp);
        n_total++; if (d !== 32'h00400102 || resp !== 2'b00) $display("FAIL info_read got=%h/%b exp=00400102/00", d, resp); else n_pass++;
        axi_write(7'h74, 32'h1, 4'hF, 1'b1, 0, resp);
        n_total++; if (resp !== 2'b10) $display("FAIL ro_write got=%b exp=10", resp); else n_pass++;
        in_consumed = 64'h0000_0000_CAFE_0001; out_produced = 32'h55;
        axi_read(7'h34, d, resp);
        n_total++; if (d !== 32'hCAFE0001) $display("FAIL consumed_read got=%h exp=cafe0001", d); else n_pass++;
        axi_read(7'h74, d, resp);
        n_total++; if (d !== 32'h55 || resp !== 2'b00) $display("FAIL produced_read got=%h/%b exp=55/00", d, resp); else n_pass++;
    endtask

    task automatic test_ap_ctrl();
        logic [1:0] resp; logic [31:0] d; int ev0, c0;
        ev0 = ev_cnt;
        axi_write(7'h00, 32'h81, 4'h1, 1'b0, 0, resp);
        n_total++; if (ap_start !== 1'b1) $display("FAIL start_set got=%b exp=1", ap_start); else n_pass++;
        n_total++; if (ev_cnt - ev0 !== 1 || event_start !== 1'b0) $display("FAIL event_pulse got=%0d exp=1", ev_cnt - ev0); else n_pass++;
        ap_ready = 1'b1; tick(); ap_ready = 1'b0; tick();
        n_total++; if (ap_start !== 1'b1) $display("FAIL autorestart_keep got=%b exp=1", ap_start); else n_pass++;
        ap_done = 1'b1; tick(); ap_done = 1'b0;
        n_total++; if (ap_continue !== 1'b1) $display("FAIL auto_continue got=%b exp=1", ap_continue); else n_pass++;
        tick();
        n_total++; if (ap_continue !== 1'b0) $display("FAIL continue_width got=%b exp=0", ap_continue); else n_pass++;
        axi_read(7'h00, d, resp);
        n_total++; if (d !== 32'h83) $display("FAIL apctrl_done got=%h exp=83", d); else n_pass++;
        axi_read(7'h00, d, resp);
        n_total++; if (d !== 32'h81) $display("FAIL apctrl_clear got=%h exp=81", d); else n_pass++;
        axi_write(7'h00, 32'h01, 4'h1, 1'b0, 0, resp);
        ap_ready = 1'b1; tick(); ap_ready = 1'b0;
        n_total++; if (ap_start !== 1'b0) $display("FAIL start_clear got=%b exp=0", ap_start); else n_pass++;
        c0 = cont_cnt;
        axi_write(7'h00, 32'h10, 4'h1, 1'b1, 1, resp);
        n_total++; if (cont_cnt - c0 !== 1 || ap_start !== 1'b0) $display("FAIL write_continue got=%0d exp=1", cont_cnt - c0); else n_pass++;
        ap_idle = 1'b1; tick();
        axi_read(7'h00, d, resp);
        n_total++; if (d[2] !== 1'b1) $display("FAIL idle_copy got=%b exp=1", d[2]); else n_pass++;
        ap_idle = 1'b0;
    endtask

    task automatic test_interrupt();
        logic [1:0] resp; logic [31:0] d; int n = 0;
        axi_write(7'h04, 32'h1, 4'h1, 1'b0, 0, resp);
        axi_write(7'h08, 32'h1, 4'h1, 1'b0, 0, resp);
        n_total++; if (interrupt !== 1'b0) $display("FAIL irq_idle got=%b exp=0", interrupt); else n_pass++;
        ap_done = 1'b1; tick(); ap_done = 1'b0;
        n_total++; if (interrupt !== 1'b1) $display("FAIL irq_set got=%b exp=1", interrupt); else n_pass++;
        // ISR toggle executes in the same cycle that ap_done is high
        AWADDR = 7'h0C; AWVALID = 1'b1; WDATA = 32'h1; WSTRB = 4'h1; WVALID = 1'b1;
        tick();
        AWVALID = 1'b0; WVALID = 1'b0; ap_done = 1'b1;
        tick();
        ap_done = 1'b0;
        while (!BVALID && n < 20) begin tick(); n++; end
        BREADY = 1'b1; tick(); BREADY = 1'b0;
        n_total++; if (interrupt !== 1'b1) $display("FAIL irq_set_wins got=%b exp=1", interrupt); else n_pass++;
        axi_read(7'h0C, d, resp);
        n_total++; if (d !== 32'h1) $display("FAIL isr_read got=%h exp=1", d); else n_pass++;
        axi_write(7'h0C, 32'h1, 4'h1, 1'b0, 0, resp);
        n_total++; if (interrupt !== 1'b0) $display("FAIL irq_toggle got=%b exp=0", interrupt); else n_pass++;
    endtask

    task automatic test_reset_midflight();
        logic [1:0] resp; logic [31:0] d; int n = 0;
        ARADDR = 7'h20; ARVALID = 1'b1;
        tick();
        ARVALID = 1'b0;
        send_aw(7'h10);
        send_w(32'hFFFFFFFF, 4'hF);
        while (!BVALID && n < 20) begin tick(); n++; end
        n_total++; if (!BVALID || !RVALID || kernel_command[31:0] !== 32'hFFFFFFFF) $display("FAIL inflight_setup got=%b%b/%h exp=11/ffffffff", BVALID, RVALID, kernel_command[31:0]); else n_pass++;
        #2 ARESETN = 1'b0;
        #1;
        n_total++; if (BVALID !== 1'b0 || RVALID !== 1'b0) $display("FAIL midrst_valids got=%b%b exp=00", BVALID, RVALID); else n_pass++;
        n_total++; if (kernel_command !== '0 || in_requested_size !== '0 || out_buffer !== '0 || ap_start !== 1'b0 || interrupt !== 1'b0) $display("FAIL midrst_outputs got=%h exp=0", kernel_command); else n_pass++;
        repeat (2) tick();
        ARESETN = 1'b1;
        repeat (2) tick();
        axi_read(7'h20, d, resp);
        n_total++; if (d !== 32'h0 || resp !== 2'b00) $display("FAIL post_reset_read got=%h/%b exp=0/00", d, resp); else n_pass++;
    endtask

    initial begin
        ARESETN = 1'b0; ACLK_EN = 1'b1;
        AWADDR = '0; AWVALID = 1'b0; WDATA = '0; WSTRB = '0; WVALID = 1'b0; BREADY = 1'b0;
        ARADDR = '0; ARVALID = 1'b0; RREADY = 1'b0;
        in_consumed = '0; out_produced = '0;
        ap_done = 1'b0; ap_ready = 1'b0; ap_idle = 1'b0;
        test_reset();
        test_write_order();
        test_strobe();
        test_errors();
        test_ap_ctrl();
        test_interrupt();
        test_reset_midflight();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
